// File: rtl/alu_mc.sv
// alu_mc: handshaked execute-stage ALU.
// Single-cycle ops complete in one cycle. Multiply, divide and remainder run
// iteratively, one bit per cycle over WIDTH cycles. The result and the zero
// flag are registered and held until the consumer takes them.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   op, rv1, rv2      operation and operands, captured on accept
//   in_valid/in_ready request handshake (ready only in IDLE)
//   rvout, alu_zero   registered result and (rvout == 0) flag
//   out_valid/out_ready result handshake
//   busy              block is not IDLE
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] rv1,
    input  logic [WIDTH-1:0] rv2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] rvout,
    output logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;      // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;      // multiplier bits / dividend -> quotient
    logic [WIDTH-1:0] b_q, b_d;        // multiplicand / divisor magnitude
    logic             neg_q, neg_d;    // negate the magnitude result at the end
    logic [1:0]       fn_q, fn_d;      // op[1:0] selects the mul/div variant
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   div_rs, div_diff;
    logic [WIDTH-1:0] div_hi_n, div_lo_n;
    logic             mul_a_sgn, mul_b_sgn, div_a_sgn, div_b_sgn;
    logic             is_mul, is_div;

    function automatic logic [WIDTH-1:0] alu_single(input logic [5:0] f,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [SHW-1:0]   sh;
        sh = b[SHW-1:0];
        case (f)
            6'b000000: r = a + b;
            6'b110000: r = a - b;
            6'b000010: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            6'b000011: r = {{(WIDTH-1){1'b0}}, (a < b)};
            6'b000100: r = a ^ b;
            6'b000110: r = a | b;
            6'b000111: r = a & b;
            6'b100000: r = a << sh;
            6'b100101: r = a >> sh;
            6'b110101: r = $unsigned($signed(a) >>> sh);
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x,
                                                 input logic neg);
        return neg ? -x : x;
    endfunction

    // Sign fix-up of the full product, then pick the low or high half.
    function automatic logic [WIDTH-1:0] mul_result(input logic [WIDTH-1:0] hi,
                                                    input logic [WIDTH-1:0] lo,
                                                    input logic neg,
                                                    input logic [1:0] fn);
        logic [2*WIDTH-1:0] p;
        p = {hi, lo};
        if (neg) p = -p;
        return (fn == 2'b00) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] div_result(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic neg,
                                                    input logic [1:0] fn);
        logic [WIDTH-1:0] m;
        m = fn[1] ? rem : quo;
        return neg ? -m : m;
    endfunction

    // State register; data-path registers carry no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    always_ff @(posedge clk) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        b_q   <= b_d;
        neg_q <= neg_d;
        fn_q  <= fn_d;
    end

    // Next-state and data-path logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        neg_d   = neg_q;
        fn_d    = fn_q;
        res_d   = res_q;
        zero_d  = zero_q;

        is_mul = (op[5:2] == 4'b0010);
        is_div = (op[5:2] == 4'b0011);

        // Shift-add step: conditionally add the multiplicand, shift right.
        mul_sum  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};

        // Restoring step: shift in the next dividend bit, trial subtract.
        // A zero divisor always "succeeds", giving an all-ones quotient and
        // the dividend magnitude as remainder.
        div_rs   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_rs - {1'b0, b_q};
        div_hi_n = div_diff[WIDTH] ? div_rs[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_lo_n = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

        mul_a_sgn = ((op[1:0] == 2'b01) || (op[1:0] == 2'b10)) && rv1[WIDTH-1];
        mul_b_sgn = (op[1:0] == 2'b01) && rv2[WIDTH-1];
        div_a_sgn = ~op[0] && rv1[WIDTH-1];
        div_b_sgn = ~op[0] && rv2[WIDTH-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    fn_d = op[1:0];
                    if (is_mul) begin
                        state_d = MUL;
                        cnt_d   = CW'(WIDTH);
                        hi_d    = '0;
                        lo_d    = abs_val(rv1, mul_a_sgn);
                        b_d     = abs_val(rv2, mul_b_sgn);
                        neg_d   = mul_a_sgn ^ mul_b_sgn;
                    end else if (is_div) begin
                        state_d = DIV;
                        cnt_d   = CW'(WIDTH);
                        hi_d    = '0;
                        lo_d    = abs_val(rv1, div_a_sgn);
                        b_d     = abs_val(rv2, div_b_sgn);
                        // Remainder follows the dividend; a divide-by-zero
                        // quotient stays all-ones, so it is never negated.
                        neg_d   = op[1] ? div_a_sgn
                                        : ((div_a_sgn ^ div_b_sgn) && (rv2 != '0));
                    end else begin
                        state_d = DONE;
                        res_d   = alu_single(op, rv1, rv2);
                        zero_d  = (res_d == '0);
                    end
                end
            end
            MUL: begin
                hi_d  = mul_hi_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = mul_result(mul_hi_n, mul_lo_n, neg_q, fn_q);
                    zero_d  = (res_d == '0);
                end
            end
            DIV: begin
                hi_d  = div_hi_n;
                lo_d  = div_lo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = div_result(div_hi_n, div_lo_n, neg_q, fn_q);
                    zero_d  = (res_d == '0);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        rvout     = res_q;
        alu_zero  = zero_q;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, handshaked successor to the processor's single-cycle combinational ALU.
- Keeps the existing 6-bit op encoding for single-cycle ops and adds RV32M-style multiply/divide/remainder, executed iteratively over WIDTH cycles.
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid.
- Result and zero flag are registered and held until consumed.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from rv2 (derived, not overridden).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high reset.
- op, input, 6, operation code (table below); sampled on accept.
- rv1, input, WIDTH, first operand; sampled on accept.
- rv2, input, WIDTH, second operand; sampled on accept.
- in_valid, input, 1, request valid.
- in_ready, output, 1, block can accept a request this cycle.
- rvout, output, WIDTH, registered result.
- alu_zero, output, 1, registered flag: 1 when rvout == 0.
- out_valid, output, 1, rvout/alu_zero valid.
- out_ready, input, 1, consumer takes result this cycle.
- busy, output, 1, state != IDLE.

Behaviour:
- Single-cycle ops:
  - 000000 add; 110000 sub; 000010 slt (signed); 000011 sltu.
  - 000100 xor; 000110 or; 000111 and.
  - 100000 sll; 100101 srl; 110101 sra (arithmetic).
  - Any undefined op: result 0.
- Shift amount is rv2[SHW-1:0]; upper rv2 bits are ignored.
- slt/sltu produce 1 or 0, zero-extended to WIDTH.
- Multi-cycle ops:
  - 001000 mul (low half); 001001 mulh (s x s, high); 001010 mulhsu (s x u, high); 001011 mulhu (u x u, high).
  - 001100 div; 001101 divu; 001110 rem; 001111 remu.
- Multiply: shift-add on magnitudes, one bit per cycle, sign fix-up in DONE entry. Divide: restoring, one quotient bit per cycle.
- Signed rem takes the dividend's sign; signed div truncates toward zero.
- Division by zero: quotient all-ones; remainder = rv1.
- Signed overflow (rv1 = most-negative, rv2 = -1): quotient = rv1; remainder = 0.
- Both special cases keep the normal WIDTH+1 latency.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready = 1. Accept when in_valid & in_ready.
    - Single-cycle or undefined op: register result, go to DONE.
    - Mul op: go to MUL. Div/rem op: go to DIV. Load iteration counter = WIDTH.
  - MUL/DIV: one iteration per cycle, counter decrements. On the last iteration, register result and go to DONE.
  - DONE: out_valid = 1; rvout/alu_zero stable. If out_ready, go to IDLE.
- in_ready = 1 only in IDLE. No accept in the same cycle the result is consumed: back-to-back throughput is one op per 2 cycles minimum.
- Latency (accept edge to out_valid high):
  - Single-cycle ops: 1 cycle.
  - Mul/div ops: WIDTH+1 cycles (33 at WIDTH=32).
- Operands and op are captured on accept. Input changes afterwards have no effect.
- out_ready while out_valid = 0 has no effect. rvout holds its last value until the next result is registered.
- alu_zero is computed from the registered result, not the inputs.
- Reset, at any time including mid-iteration or in DONE, takes effect at the next edge:
  - state = IDLE; counter = 0; rvout = 0; alu_zero = 1; out_valid = 0; busy = 0; in_ready = 1.
  - Any in-flight result is discarded.
- Arithmetic wraps modulo 2^WIDTH. No overflow flags.

Test Plan:
- Single-cycle ops: add 0xFFFFFFFF+1 -> rvout 0, alu_zero 1, out_valid 1 cycle after accept. sra 0x80000000 by rv2=0x21 -> 0xC0000000 (shift 1). slt -1<1 -> 1; sltu -> 0.
- Multiply: mulh 0xFFFFFFFF x 0xFFFFFFFF -> 0; mulhu same -> 0xFFFFFFFE; mul 7 x -3 -> 0xFFFFFFEB. out_valid exactly 33 cycles after accept; in_ready 0 throughout.
- Divide: div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF. divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5. div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem of the same -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after a result -> rvout stable, in_ready 0, new in_valid ignored. Raise out_ready -> IDLE next cycle; next request accepted.
- Reset mid-divide: assert reset at iteration 10 -> next cycle out_valid 0, rvout 0, in_ready 1. A fresh add 2+3 then returns 5.
- WIDTH=8 instance: mulhu 0xFF x 0xFF -> 0xFE with latency 9. sll by rv2=0x0B -> shift 3.
